// File: rtl/spim_pkg.sv
// spim_pkg: shared types and constants for my_spi_master.
// FSM states, frame bit positions, divider limits.
package spim_pkg;

  typedef enum logic [2:0] {
    S_Idle,
    S_Setup,
    S_High,
    S_Low,
    S_Gap,
    S_Done
  } state_e;

  localparam int FRM_W     = 32;
  localparam int FRM_WR    = 31;
  localparam int FRM_A_HI  = 30;
  localparam int FRM_A_LO  = 16;
  localparam int FRM_D_HI  = 15;
  localparam int FRM_D_LO  = 0;

  localparam int HALF_DIV_MIN = 6;
  localparam int HALF_DIV_MAX = 255;

  function automatic logic [FRM_W-1:0] mk_frame(
    input logic        wr,
    input logic [14:0] addr,
    input logic [15:0] data
  );
    logic [FRM_W-1:0] f;
    f = '0;
    f[FRM_WR] = wr;
    f[FRM_A_HI:FRM_A_LO] = addr;
    f[FRM_D_HI:FRM_D_LO] = wr ? data : 16'h0;
    return f;
  endfunction

endpackage

// File: rtl/my_spi_master_if.sv
// my_spi_master_if: request/response handshake bundle.
// master = requesting logic, slave = the SPI master block.
interface my_spi_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spim_tick.sv
// spim_tick: loadable down-counter, strobes at the end of
// every HALF_DIV-cycle phase.
module spim_tick
  import spim_pkg::*;
#(
  parameter int HALF_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int HD = (HALF_DIV < HALF_DIV_MIN) ? HALF_DIV_MIN :
                      (HALF_DIV > HALF_DIV_MAX) ? HALF_DIV_MAX :
                      HALF_DIV;
  localparam logic [7:0] RELOAD = 8'(HD - 1);

  logic [7:0] cnt_q, cnt_d;

  // reload on request or at phase end, otherwise count down
  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (load || cnt_q == 8'd0) cnt_d = RELOAD;
  end

  assign tick = !load && (cnt_q == 8'd0);

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/my_spi_master.sv
// my_spi_master: 32-bit MySPI register master (CS low, SCLK idle low).
// Define SPIM_WRITE_VERIFY_EN to follow each write with a readback.
module my_spi_master
  import spim_pkg::*;
#(
  parameter int HALF_DIV = 8
) (
  input  logic          theClock,
  input  logic          theReset,
  my_spi_master_if.slave bus,
  output logic          spi_cs,
  output logic          spi_clk,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  state_e      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        clk_q, clk_d;
  logic        mosi_q, mosi_d;
  logic        vld_q, vld_d;
  logic        hi1_q, hi1_d;
  logic [1:0]  sync_q;
  logic        miso_s;
  logic        tick;
  logic        load;
  logic        accept;

`ifdef SPIM_WRITE_VERIFY_EN
  logic        vfy_q, vfy_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
`endif

  assign load   = (state_q == S_Idle) || (state_q == S_Done);
  assign miso_s = sync_q[1];

  spim_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk  (theClock),
    .rst  (theReset),
    .load (load),
    .tick (tick)
  );

  assign bus.req_ready = (state_q == S_Idle) && !vld_q && !theReset;
  assign accept        = bus.req_valid && bus.req_ready;

  // next-state, shifting and pin values
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rdata_d = rdata_q;
    mosi_d  = mosi_q;
    vld_d   = 1'b0;
`ifdef SPIM_WRITE_VERIFY_EN
    vfy_d   = vfy_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`endif
    unique case (state_q)
      S_Idle: begin
        if (accept) begin
          frame_d = mk_frame(bus.req_write, bus.req_addr,
                             bus.req_wdata);
          mosi_d  = bus.req_write;
          bit_d   = '0;
          state_d = S_Setup;
`ifdef SPIM_WRITE_VERIFY_EN
          vfy_d   = 1'b0;
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`endif
        end
      end
      S_Setup: begin
        if (tick) state_d = S_High;
      end
      S_High: begin
        if (hi1_q && bit_q[4])
          shreg_d = {shreg_q[14:0], miso_s};
        if (tick) begin
          frame_d = {frame_q[30:0], 1'b0};
          mosi_d  = frame_q[FRM_WR-1];
          state_d = S_Low;
        end
      end
      S_Low: begin
        if (tick) begin
          if (bit_q == 5'd31) begin
            mosi_d  = 1'b0;
            state_d = S_Gap;
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = S_High;
          end
        end
      end
      S_Gap: begin
        if (tick) begin
          state_d = S_Done;
`ifdef SPIM_WRITE_VERIFY_EN
          if (wr_q && !vfy_q) begin
            vfy_d   = 1'b1;
            frame_d = mk_frame(1'b0, addr_q, 16'h0);
            mosi_d  = 1'b0;
            bit_d   = '0;
            state_d = S_Setup;
          end
`endif
        end
      end
      S_Done: begin
        vld_d   = 1'b1;
        rdata_d = shreg_q;
`ifdef SPIM_WRITE_VERIFY_EN
        err_d   = vfy_q && (shreg_q != wdata_q);
`endif
        state_d = S_Idle;
      end
      default: state_d = S_Idle;
    endcase
    cs_d  = !((state_d == S_Setup) || (state_d == S_High) ||
              (state_d == S_Low));
    clk_d = (state_d == S_High);
    hi1_d = (state_d == S_High) && (state_q != S_High);
  end

  // main state and pin registers
  always_ff @(posedge theClock) begin
    if (theReset) begin
      state_q <= S_Idle;
      frame_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b1;
      clk_q   <= 1'b0;
      mosi_q  <= 1'b0;
      vld_q   <= 1'b0;
      hi1_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      clk_q   <= clk_d;
      mosi_q  <= mosi_d;
      vld_q   <= vld_d;
      hi1_q   <= hi1_d;
      sync_q  <= {sync_q[0], spi_miso};
    end
  end

`ifdef SPIM_WRITE_VERIFY_EN
  // readback bookkeeping for write verification
  always_ff @(posedge theClock) begin
    if (theReset) begin
      vfy_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      vfy_q   <= vfy_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign spi_cs        = cs_q;
  assign spi_clk       = clk_q;
  assign spi_mosi      = mosi_q;

endmodule
